// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: one requester port of the data-memory arbiter.
// master = requester side, slave = arbiter side.
interface dm_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin sharing of the 4K data memory, IDLE/ACCESS/RESP.
// Optional counters gnt_cnt0/gnt_cnt1/conflict_cnt under DM_ARB_STATS_EN.
module dm_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  dm_arbiter_if.slave       m0,
  dm_arbiter_if.slave       m1,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic              dm_wEn,
  input  logic [DATA_W-1:0] dm_dout
`ifdef DM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1,
  output logic [CNT_W-1:0]  conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_gnt_q, last_gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic gnt_v;
  logic gnt_sel;
  logic both_req;

  assign both_req = m0.req & m1.req;
  assign gnt_v    = m0.req | m1.req;
  // On a tie the port that did not win last time goes next.
  assign gnt_sel  = both_req ? ~last_gnt_q : m1.req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_v) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    if (state_q == IDLE && gnt_v) begin
      owner_d    = gnt_sel;
      last_gnt_d = gnt_sel;
      we_d       = gnt_sel ? m1.we    : m0.we;
      addr_d     = gnt_sel ? m1.addr  : m0.addr;
      wdata_d    = gnt_sel ? m1.wdata : m0.wdata;
    end
    if (state_q == ACCESS && !we_q) begin
      if (owner_q) rdata1_d = dm_dout;
      else         rdata0_d = dm_dout;
    end
  end

  always_comb begin
    dm_addr = '0;
    dm_din  = '0;
    dm_wEn  = 1'b0;
    m0.ack  = 1'b0;
    m1.ack  = 1'b0;
    unique case (1'b1)
      (state_q == ACCESS): begin
        dm_addr = addr_q;
        dm_din  = wdata_q;
        dm_wEn  = we_q;
      end
      (state_q == RESP): begin
        m0.ack = ~owner_q;
        m1.ack = owner_q;
      end
      default: ;
    endcase
  end

  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;

`ifdef DM_ARB_STATS_EN
  logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [CNT_W-1:0] gnt_cnt1_q, gnt_cnt1_d;
  logic [CNT_W-1:0] conflict_q, conflict_d;

  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    conflict_d = conflict_q;
    if (state_q == IDLE && gnt_v) begin
      if (gnt_sel) gnt_cnt1_d = gnt_cnt1_q + 1'b1;
      else         gnt_cnt0_d = gnt_cnt0_q + 1'b1;
      if (both_req) conflict_d = conflict_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
      conflict_q <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
      conflict_q <= conflict_d;
    end
  end

  assign gnt_cnt0     = gnt_cnt0_q;
  assign gnt_cnt1     = gnt_cnt1_q;
  assign conflict_cnt = conflict_q;
`endif

endmodule
